// File: rtl/ysyx_2022040010_axi_sched.sv
// ysyx_2022040010_axi_sched
// Sequences one memory transaction at a time from the icache, dcache or
// uncache client onto a single-beat AXI4 master port and returns read data
// or write completion to the granted client with a one-cycle done pulse.
// Optional feature: define ARB_RR_EN for round-robin arbitration; otherwise
// the fixed order dcache > uncache > icache is used.
module ysyx_2022040010_axi_sched #(
    parameter int ID_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    // icache client (read only)
    input  logic            icache_req_i,
    input  logic [31:0]     icache_addr_i,
    output logic            icache_done_o,
    output logic [63:0]     icache_rdata_o,
    output logic            icache_err_o,
    // dcache client
    input  logic            dcache_req_i,
    input  logic            dcache_we_i,
    input  logic [31:0]     dcache_addr_i,
    input  logic [63:0]     dcache_wdata_i,
    input  logic [7:0]      dcache_mask_i,
    output logic            dcache_done_o,
    output logic [63:0]     dcache_rdata_o,
    output logic            dcache_err_o,
    // uncache client
    input  logic            uncache_req_i,
    input  logic            uncache_we_i,
    input  logic [31:0]     uncache_addr_i,
    input  logic [63:0]     uncache_wdata_i,
    input  logic [7:0]      uncache_mask_i,
    output logic            uncache_done_o,
    output logic [63:0]     uncache_rdata_o,
    output logic            uncache_err_o,
    // AXI read address / data
    output logic            ar_valid_o,
    input  logic            ar_ready_i,
    output logic [ID_W-1:0] ar_id_o,
    output logic [31:0]     ar_addr_o,
    input  logic            r_valid_i,
    output logic            r_ready_o,
    input  logic [ID_W-1:0] r_id_i,
    input  logic [63:0]     r_data_i,
    input  logic [1:0]      r_resp_i,
    // AXI write address / data / response
    output logic            aw_valid_o,
    input  logic            aw_ready_i,
    output logic [ID_W-1:0] aw_id_o,
    output logic [31:0]     aw_addr_o,
    output logic            w_valid_o,
    input  logic            w_ready_i,
    output logic [63:0]     w_data_o,
    output logic [7:0]      w_strb_o,
    input  logic            b_valid_i,
    output logic            b_ready_o,
    input  logic [ID_W-1:0] b_id_i,
    input  logic [1:0]      b_resp_i
);

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AWW, S_B, S_RESP} state_t;

    // Client codes double as AXI IDs.
    localparam logic [1:0] C_ICACHE  = 2'd0;
    localparam logic [1:0] C_DCACHE  = 2'd1;
    localparam logic [1:0] C_UNCACHE = 2'd2;

    state_t      state;
    logic [1:0]  gnt;
    logic [3:0]  req_vec;
    logic        any_req;
    logic [1:0]  win;
    logic        win_we;
    logic [31:0] win_addr;
    logic [63:0] win_wdata;
    logic [7:0]  win_mask;
    logic        fin;
    logic [63:0] fin_data;
    logic        fin_err;

    assign req_vec = {1'b0, uncache_req_i, dcache_req_i, icache_req_i};
    assign any_req = |req_vec;

`ifdef ARB_RR_EN
    logic [1:0] last_gnt;
    logic [1:0] cand0, cand1, cand2;

    // Rotation order: dcache -> uncache -> icache -> dcache.
    function automatic logic [1:0] next_client(input logic [1:0] c);
        case (c)
            C_DCACHE:  next_client = C_UNCACHE;
            C_UNCACHE: next_client = C_ICACHE;
            default:   next_client = C_DCACHE;
        endcase
    endfunction

    // Round-robin winner: search starts just after the last granted client.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        win   = C_DCACHE;
        cand0 = next_client(last_gnt);
        cand1 = next_client(cand0);
        cand2 = next_client(cand1);
        if (req_vec[cand0])      win = cand0;
        else if (req_vec[cand1]) win = cand1;
        else                     win = cand2;
    end

    // Remember the last grant; reset value makes dcache the first choice.
    always_ff @(posedge clk) begin
        if (!rst)                          last_gnt <= C_ICACHE;
        else if (state == S_IDLE && any_req) last_gnt <= win;
    end
`else
    // Fixed-priority winner: dcache > uncache > icache.
    always_comb begin
        win = C_ICACHE;
        if (dcache_req_i)       win = C_DCACHE;
        else if (uncache_req_i) win = C_UNCACHE;
    end
`endif

    // Request fields of the current winner.
    always_comb begin
        win_we    = 1'b0;
        win_addr  = icache_addr_i;
        win_wdata = '0;
        win_mask  = '0;
        case (win)
            C_DCACHE: begin
                win_we    = dcache_we_i;
                win_addr  = dcache_addr_i;
                win_wdata = dcache_wdata_i;
                win_mask  = dcache_mask_i;
            end
            C_UNCACHE: begin
                win_we    = uncache_we_i;
                win_addr  = uncache_addr_i;
                win_wdata = uncache_wdata_i;
                win_mask  = uncache_mask_i;
            end
            default: ;
        endcase
    end

    // Completion decode: the R or B beat that ends the transaction.
    always_comb begin
        fin      = 1'b0;
        fin_data = '0;
        fin_err  = 1'b0;
        if (state == S_R && r_valid_i) begin
            fin      = 1'b1;
            fin_data = r_data_i;
            fin_err  = (r_resp_i != 2'b00) || (r_id_i != ID_W'(gnt));
        end else if (state == S_B && b_valid_i) begin
            fin      = 1'b1;
            fin_err  = (b_resp_i != 2'b00) || (b_id_i != ID_W'(gnt));
        end
    end

    // Transaction FSM with all AXI and client outputs registered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= S_IDLE;
            gnt             <= C_ICACHE;
            ar_valid_o      <= 1'b0;
            ar_id_o         <= '0;
            ar_addr_o       <= '0;
            r_ready_o       <= 1'b0;
            aw_valid_o      <= 1'b0;
            aw_id_o         <= '0;
            aw_addr_o       <= '0;
            w_valid_o       <= 1'b0;
            w_data_o        <= '0;
            w_strb_o        <= '0;
            b_ready_o       <= 1'b0;
            icache_done_o   <= 1'b0;
            icache_rdata_o  <= '0;
            icache_err_o    <= 1'b0;
            dcache_done_o   <= 1'b0;
            dcache_rdata_o  <= '0;
            dcache_err_o    <= 1'b0;
            uncache_done_o  <= 1'b0;
            uncache_rdata_o <= '0;
            uncache_err_o   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here; these defaults are overridden below and make done a single-cycle pulse.
            icache_done_o   <= 1'b0;
            icache_rdata_o  <= '0;
            icache_err_o    <= 1'b0;
            dcache_done_o   <= 1'b0;
            dcache_rdata_o  <= '0;
            dcache_err_o    <= 1'b0;
            uncache_done_o  <= 1'b0;
            uncache_rdata_o <= '0;
            uncache_err_o   <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        gnt <= win;
                        if (win_we) begin
                            aw_valid_o <= 1'b1;
                            w_valid_o  <= 1'b1;
                            aw_id_o    <= ID_W'(win);
                            aw_addr_o  <= win_addr;
                            w_data_o   <= win_wdata;
                            w_strb_o   <= win_mask;
                            state      <= S_AWW;
                        end else begin
                            ar_valid_o <= 1'b1;
                            ar_id_o    <= ID_W'(win);
                            ar_addr_o  <= win_addr;
                            state      <= S_AR;
                        end
                    end
                end
                S_AR: begin
                    if (ar_ready_i) begin
                        ar_valid_o <= 1'b0;
                        r_ready_o  <= 1'b1;
                        state      <= S_R;
                    end
                end
                S_R: begin
                    if (r_valid_i) begin
                        r_ready_o <= 1'b0;
                        state     <= S_RESP;
                    end
                end
                S_AWW: begin
                    // AW and W complete independently, in either order.
                    if (aw_ready_i) aw_valid_o <= 1'b0;
                    if (w_ready_i)  w_valid_o  <= 1'b0;
                    if ((!aw_valid_o || aw_ready_i) && (!w_valid_o || w_ready_i)) begin
                        b_ready_o <= 1'b1;
                        state     <= S_B;
                    end
                end
                S_B: begin
                    if (b_valid_i) begin
                        b_ready_o <= 1'b0;
                        state     <= S_RESP;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            if (fin) begin
                case (gnt)
                    C_DCACHE: begin
                        dcache_done_o  <= 1'b1;
                        dcache_rdata_o <= fin_data;
                        dcache_err_o   <= fin_err;
                    end
                    C_UNCACHE: begin
                        uncache_done_o  <= 1'b1;
                        uncache_rdata_o <= fin_data;
                        uncache_err_o   <= fin_err;
                    end
                    default: begin
                        icache_done_o  <= 1'b1;
                        icache_rdata_o <= fin_data;
                        icache_err_o   <= fin_err;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ysyx_2022040010_axi_sched.sv
// Directed self-checking bench for ysyx_2022040010_axi_sched.
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge. Define ARB_RR_EN here as for the RTL to select the
// round-robin expectations.
module tb_ysyx_2022040010_axi_sched;

    logic        clk;
    logic        rst;
    logic        icache_req_i;
    logic [31:0] icache_addr_i;
    logic        icache_done_o;
    logic [63:0] icache_rdata_o;
    logic        icache_err_o;
    logic        dcache_req_i, dcache_we_i;
    logic [31:0] dcache_addr_i;
    logic [63:0] dcache_wdata_i;
    logic [7:0]  dcache_mask_i;
    logic        dcache_done_o;
    logic [63:0] dcache_rdata_o;
    logic        dcache_err_o;
    logic        uncache_req_i, uncache_we_i;
    logic [31:0] uncache_addr_i;
    logic [63:0] uncache_wdata_i;
    logic [7:0]  uncache_mask_i;
    logic        uncache_done_o;
    logic [63:0] uncache_rdata_o;
    logic        uncache_err_o;
    logic        ar_valid_o, ar_ready_i;
    logic [3:0]  ar_id_o;
    logic [31:0] ar_addr_o;
    logic        r_valid_i, r_ready_o;
    logic [3:0]  r_id_i;
    logic [63:0] r_data_i;
    logic [1:0]  r_resp_i;
    logic        aw_valid_o, aw_ready_i;
    logic [3:0]  aw_id_o;
    logic [31:0] aw_addr_o;
    logic        w_valid_o, w_ready_i;
    logic [63:0] w_data_o;
    logic [7:0]  w_strb_o;
    logic        b_valid_i, b_ready_o;
    logic [3:0]  b_id_i;
    logic [1:0]  b_resp_i;

    int checks   = 0;
    int failures = 0;

    // Every output in one vector for the "all zero" checks (347 bits).
    logic [346:0] all_out;
    assign all_out = {ar_valid_o, r_ready_o, aw_valid_o, w_valid_o, b_ready_o,
                      icache_done_o, dcache_done_o, uncache_done_o,
                      icache_err_o, dcache_err_o, uncache_err_o,
                      icache_rdata_o, dcache_rdata_o, uncache_rdata_o,
                      ar_id_o, ar_addr_o, aw_id_o, aw_addr_o, w_data_o, w_strb_o};

    ysyx_2022040010_axi_sched #(.ID_W(4)) dut (
        .clk(clk), .rst(rst),
        .icache_req_i(icache_req_i), .icache_addr_i(icache_addr_i),
        .icache_done_o(icache_done_o), .icache_rdata_o(icache_rdata_o), .icache_err_o(icache_err_o),
        .dcache_req_i(dcache_req_i), .dcache_we_i(dcache_we_i), .dcache_addr_i(dcache_addr_i),
        .dcache_wdata_i(dcache_wdata_i), .dcache_mask_i(dcache_mask_i),
        .dcache_done_o(dcache_done_o), .dcache_rdata_o(dcache_rdata_o), .dcache_err_o(dcache_err_o),
        .uncache_req_i(uncache_req_i), .uncache_we_i(uncache_we_i), .uncache_addr_i(uncache_addr_i),
        .uncache_wdata_i(uncache_wdata_i), .uncache_mask_i(uncache_mask_i),
        .uncache_done_o(uncache_done_o), .uncache_rdata_o(uncache_rdata_o), .uncache_err_o(uncache_err_o),
        .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_id_o(ar_id_o), .ar_addr_o(ar_addr_o),
        .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_id_i(r_id_i), .r_data_i(r_data_i), .r_resp_i(r_resp_i),
        .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_id_o(aw_id_o), .aw_addr_o(aw_addr_o),
        .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o), .w_strb_o(w_strb_o),
        .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_id_i(b_id_i), .b_resp_i(b_resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        icache_req_i = 0;  icache_addr_i = '0;
        dcache_req_i = 0;  dcache_we_i = 0;  dcache_addr_i = '0;  dcache_wdata_i = '0;  dcache_mask_i = '0;
        uncache_req_i = 0; uncache_we_i = 0; uncache_addr_i = '0; uncache_wdata_i = '0; uncache_mask_i = '0;
        ar_ready_i = 0; r_valid_i = 0; r_id_i = '0; r_data_i = '0; r_resp_i = '0;
        aw_ready_i = 0; w_ready_i = 0; b_valid_i = 0; b_id_i = '0; b_resp_i = '0;
    endtask

    // Reset for two edges with idle inputs; returns just after an edge with rst released.
    task automatic apply_reset();
        rst = 0;
        clear_inputs();
        tick();
        tick();
        rst = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 0;
        icache_req_i = 1; dcache_req_i = 1; uncache_req_i = 1;
        dcache_addr_i = 32'h8000_2000; icache_addr_i = 32'h8000_0040; uncache_addr_i = 32'h1000_0000;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        checks++;
        if (all_out !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", all_out); end
        tick();
        rst = 1;
        @(negedge clk);
        checks++;
        if (all_out !== '0) begin failures++; $display("FAIL reset_held got=%h exp=0", all_out); end
        @(negedge clk);
        checks++;
        if ({ar_valid_o, aw_valid_o, ar_id_o, ar_addr_o} !== {1'b1, 1'b0, 4'd1, 32'h8000_2000}) begin
            failures++;
            $display("FAIL reset_first_grant got=%b/%b/%h/%h exp=1/0/1/80002000", ar_valid_o, aw_valid_o, ar_id_o, ar_addr_o);
        end
        tick();
        apply_reset();
    endtask

    task automatic test_icache_read();
        icache_addr_i = 32'h8000_0000; icache_req_i = 1;            // cycle 0
        @(negedge clk);
        checks++;
        if (ar_valid_o !== 1'b0) begin failures++; $display("FAIL ic_c0_ar got=%b exp=0", ar_valid_o); end
        tick(); ar_ready_i = 1;                                      // cycle 1: AR
        @(negedge clk);
        checks++;
        if ({ar_valid_o, ar_id_o, ar_addr_o} !== {1'b1, 4'd0, 32'h8000_0000}) begin
            failures++; $display("FAIL ic_ar got=%b/%h/%h exp=1/0/80000000", ar_valid_o, ar_id_o, ar_addr_o);
        end
        tick(); ar_ready_i = 0;                                      // cycle 2: R, wait 1
        @(negedge clk);
        checks++;
        if ({ar_valid_o, r_ready_o} !== 2'b01) begin failures++; $display("FAIL ic_r_entry got=%b exp=01", {ar_valid_o, r_ready_o}); end
        tick();                                                      // cycle 3: wait 2
        @(negedge clk);
        checks++;
        if ({r_ready_o, icache_done_o} !== 2'b10) begin failures++; $display("FAIL ic_r_wait got=%b exp=10", {r_ready_o, icache_done_o}); end
        tick();                                                      // cycle 4: R beat
        r_valid_i = 1; r_data_i = 64'h1122_3344_5566_7788; r_id_i = 4'd0; r_resp_i = 2'b00;
        @(negedge clk);
        checks++;
        if (icache_done_o !== 1'b0) begin failures++; $display("FAIL ic_early_done got=%b exp=0", icache_done_o); end
        tick(); r_valid_i = 0;                                       // cycle 5: RESP
        @(negedge clk);
        checks++;
        if ({icache_done_o, icache_err_o, icache_rdata_o} !== {1'b1, 1'b0, 64'h1122_3344_5566_7788}) begin
            failures++; $display("FAIL ic_done got=%b/%b/%h exp=1/0/1122334455667788", icache_done_o, icache_err_o, icache_rdata_o);
        end
        checks++;
        if ({dcache_done_o, uncache_done_o, dcache_rdata_o, uncache_rdata_o} !== '0) begin
            failures++; $display("FAIL ic_others got=%b/%b exp=0/0", dcache_done_o, uncache_done_o);
        end
        tick(); icache_req_i = 0;                                    // cycle 6: IDLE
        @(negedge clk);
        checks++;
        if ({icache_done_o, icache_rdata_o} !== '0) begin failures++; $display("FAIL ic_pulse_width got=%b exp=0", icache_done_o); end
        tick();                                                      // cycle 7
        @(negedge clk);
        checks++;
        if (ar_valid_o !== 1'b0) begin failures++; $display("FAIL ic_no_regrant got=%b exp=0", ar_valid_o); end
        tick();
    endtask

    task automatic test_dcache_write();
        dcache_we_i = 1; dcache_addr_i = 32'h8000_1000;
        dcache_wdata_i = 64'hDEAD_BEEF_0000_0001; dcache_mask_i = 8'h0F; dcache_req_i = 1;   // cycle 0
        tick(); aw_ready_i = 1;                                      // cycle 1: AW+W
        @(negedge clk);
        checks++;
        if ({aw_valid_o, w_valid_o, aw_id_o, aw_addr_o, w_data_o, w_strb_o} !==
            {1'b1, 1'b1, 4'd1, 32'h8000_1000, 64'hDEAD_BEEF_0000_0001, 8'h0F}) begin
            failures++; $display("FAIL dw_entry got=%b%b/%h/%h/%h/%h", aw_valid_o, w_valid_o, aw_id_o, aw_addr_o, w_data_o, w_strb_o);
        end
        tick(); aw_ready_i = 0;                                      // cycle 2: AW done
        @(negedge clk);
        checks++;
        if ({aw_valid_o, w_valid_o, w_data_o, w_strb_o} !== {1'b0, 1'b1, 64'hDEAD_BEEF_0000_0001, 8'h0F}) begin
            failures++; $display("FAIL dw_aw_drop got=%b%b/%h/%h exp=01", aw_valid_o, w_valid_o, w_data_o, w_strb_o);
        end
        tick();                                                      // cycle 3
        @(negedge clk);
        checks++;
        if ({w_valid_o, b_ready_o} !== 2'b10) begin failures++; $display("FAIL dw_w_hold got=%b exp=10", {w_valid_o, b_ready_o}); end
        tick(); w_ready_i = 1;                                       // cycle 4: W handshake
        @(negedge clk);
        tick(); w_ready_i = 0; b_valid_i = 1; b_id_i = 4'd1; b_resp_i = 2'b00;   // cycle 5: B
        @(negedge clk);
        checks++;
        if ({aw_valid_o, w_valid_o, b_ready_o} !== 3'b001) begin
            failures++; $display("FAIL dw_b got=%b exp=001", {aw_valid_o, w_valid_o, b_ready_o});
        end
        tick(); b_valid_i = 0;                                       // cycle 6: RESP
        @(negedge clk);
        checks++;
        if ({dcache_done_o, dcache_err_o, dcache_rdata_o, icache_done_o, uncache_done_o} !== {1'b1, 1'b0, 64'd0, 1'b0, 1'b0}) begin
            failures++; $display("FAIL dw_done got=%b/%b/%h/%b/%b exp=1/0/0/0/0", dcache_done_o, dcache_err_o, dcache_rdata_o, icache_done_o, uncache_done_o);
        end
        tick(); dcache_req_i = 0; dcache_we_i = 0;
        @(negedge clk);
        checks++;
        if (dcache_done_o !== 1'b0) begin failures++; $display("FAIL dw_pulse_width got=%b exp=0", dcache_done_o); end
        tick();
    endtask

    // Zero-wait uncache read; the caller's r_id/r_resp/r_data decide err and data.
    task automatic uncache_read(input logic [31:0] addr, input logic [3:0] rid,
                                input logic [1:0] resp, input logic [63:0] data, input string tag);
        uncache_we_i = 0; uncache_addr_i = addr; uncache_req_i = 1;
        tick(); ar_ready_i = 1;
        @(negedge clk);
        checks++;
        if ({ar_valid_o, ar_id_o, ar_addr_o} !== {1'b1, 4'd2, addr}) begin
            failures++; $display("FAIL %s_ar got=%b/%h/%h exp=1/2/%h", tag, ar_valid_o, ar_id_o, ar_addr_o, addr);
        end
        tick(); ar_ready_i = 0; r_valid_i = 1; r_id_i = rid; r_resp_i = resp; r_data_i = data;
        tick(); r_valid_i = 0; r_id_i = '0; r_resp_i = '0;
        @(negedge clk);
        checks++;
        if ({uncache_done_o, uncache_err_o, uncache_rdata_o} !== {1'b1, 1'b1, data}) begin
            failures++; $display("FAIL %s_done got=%b/%b/%h exp=1/1/%h", tag, uncache_done_o, uncache_err_o, uncache_rdata_o, data);
        end
        tick(); uncache_req_i = 0;
        @(negedge clk);
        checks++;
        if ({uncache_done_o, uncache_err_o} !== 2'b00) begin
            failures++; $display("FAIL %s_clear got=%b exp=00", tag, {uncache_done_o, uncache_err_o});
        end
        tick();
    endtask

    task automatic test_uncache_err();
        uncache_read(32'h1000_0000, 4'd2, 2'b10, 64'h0000_0000_0000_00A5, "uc_resp");
        uncache_read(32'h1000_0008, 4'd3, 2'b00, 64'h0000_0000_0000_005A, "uc_id");
    endtask

    task automatic test_reset_mid_read();
        dcache_we_i = 0; dcache_addr_i = 32'h8000_3000; dcache_req_i = 1;
        tick(); ar_ready_i = 1;                                      // AR
        tick(); ar_ready_i = 0;                                      // R
        @(negedge clk);
        checks++;
        if (r_ready_o !== 1'b1) begin failures++; $display("FAIL rm_in_r got=%b exp=1", r_ready_o); end
        rst = 0; r_valid_i = 1; r_id_i = 4'd1; r_resp_i = 2'b00; r_data_i = 64'hCAFE;
        tick(); rst = 1; r_valid_i = 0; dcache_req_i = 0;
        @(negedge clk);
        checks++;
        if (all_out !== '0) begin failures++; $display("FAIL rm_no_done got=%h exp=0", all_out); end
        tick(); dcache_req_i = 1;
        @(negedge clk);
        checks++;
        if (all_out !== '0) begin failures++; $display("FAIL rm_idle got=%h exp=0", all_out); end
        tick();
        @(negedge clk);
        checks++;
        if ({ar_valid_o, ar_addr_o} !== {1'b1, 32'h8000_3000}) begin
            failures++; $display("FAIL rm_regrant got=%b/%h exp=1/80003000", ar_valid_o, ar_addr_o);
        end
        tick();
        apply_reset();
    endtask

    // All clients keep requesting; each drops req for one cycle after its done.
    task automatic test_back_to_back();
        int got_id[$];
        int got_cyc[$];
        int exp_id[6];
        logic [2:0] d;
        logic [2:0] raise_m;
`ifdef ARB_RR_EN
        exp_id = '{1, 2, 0, 1, 2, 0};
`else
        exp_id = '{1, 2, 1, 2, 1, 2};
`endif
        raise_m = '0;
        ar_ready_i = 1; aw_ready_i = 1; w_ready_i = 1; r_valid_i = 1; b_valid_i = 1;
        dcache_we_i = 0; dcache_addr_i = 32'h8000_4000;
        uncache_we_i = 1; uncache_addr_i = 32'h1000_0010; uncache_wdata_i = 64'h77; uncache_mask_i = 8'hFF;
        icache_addr_i = 32'h8000_0080;
        icache_req_i = 1; dcache_req_i = 1; uncache_req_i = 1;
        for (int cyc = 0; cyc < 60 && got_id.size() < 6; cyc++) begin
            @(negedge clk);
            d = {uncache_done_o, dcache_done_o, icache_done_o};
            if (d != 3'b000) begin
                got_cyc.push_back(cyc);
                case (d)
                    3'b001:  got_id.push_back(0);
                    3'b010:  got_id.push_back(1);
                    3'b100:  got_id.push_back(2);
                    default: begin
                        got_id.push_back(9);
                        checks++; failures++;
                        $display("FAIL b2b_multi_done got=%b", d);
                    end
                endcase
            end
            tick();
            if (raise_m[0]) icache_req_i = 1;
            if (raise_m[1]) dcache_req_i = 1;
            if (raise_m[2]) uncache_req_i = 1;
            if (d[0]) icache_req_i = 0;
            if (d[1]) dcache_req_i = 0;
            if (d[2]) uncache_req_i = 0;
            raise_m = d;
        end
        checks++;
        if (got_id.size() != 6) begin
            failures++; $display("FAIL b2b_timeout got=%0d dones exp=6", got_id.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (got_id[i] != exp_id[i]) begin
                    failures++; $display("FAIL b2b_grant[%0d] got=%0d exp=%0d", i, got_id[i], exp_id[i]);
                end
            end
            checks++;
            if (got_cyc[0] != 3) begin failures++; $display("FAIL b2b_first got=%0d exp=3", got_cyc[0]); end
            for (int i = 1; i < 6; i++) begin
                checks++;
                if (got_cyc[i] - got_cyc[i-1] != 4) begin
                    failures++; $display("FAIL b2b_spacing[%0d] got=%0d exp=4", i, got_cyc[i] - got_cyc[i-1]);
                end
            end
        end
        apply_reset();
    endtask

    initial begin
        rst = 0;
        clear_inputs();
        test_reset();
        test_icache_read();
        test_dcache_write();
        test_uncache_err();
        test_reset_mid_read();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ysyx_2022040010_axi_sched.md
# ysyx_2022040010_axi_sched

Sequencing arbiter between the three memory clients (icache, dcache, uncache) and the single-beat AXI4 master port of the core. It accepts one request at a time, drives the AR/R or AW/W/B channel handshakes to completion, and returns read data or write completion to the granted client with a one-cycle done pulse. Sits between the cache/uncache miss logic and the AXI bridge; one transaction is outstanding at a time.

## Interface
- `ID_W`, 4, AXI ID width; IDs are icache=0, dcache=1, uncache=2.
- `clk`  in  1  core clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `icache_req_i` in 1, `icache_addr_i` in 32: read-only client; no write path.
- `dcache_req_i` / `uncache_req_i` in 1: request, held until the matching `_done_o`.
- `dcache_we_i` / `uncache_we_i` in 1: 1 = write, 0 = read.
- `{dcache,uncache}_addr_i` in 32, `_wdata_i` in 64, `_mask_i` in 8: address, write data, byte strobes.
- `{icache,dcache,uncache}_done_o`  out  1  one-cycle completion pulse.
- `{icache,dcache,uncache}_rdata_o`  out  64  read data, valid while done is high.
- `{icache,dcache,uncache}_err_o`  out  1  error flag, valid while done is high.
- `ar_valid_o` out 1, `ar_ready_i` in 1, `ar_id_o` out ID_W, `ar_addr_o` out 32.
- `r_valid_i` in 1, `r_ready_o` out 1, `r_id_i` in ID_W, `r_data_i` in 64, `r_resp_i` in 2.
- `aw_valid_o` out 1, `aw_ready_i` in 1, `aw_id_o` out ID_W, `aw_addr_o` out 32.
- `w_valid_o` out 1, `w_ready_i` in 1, `w_data_o` out 64, `w_strb_o` out 8.
- `b_valid_i` in 1, `b_ready_o` out 1, `b_id_i` in ID_W, `b_resp_i` in 2.

## Operation
- States: IDLE, AR, R, AWW, B, RESP.
- IDLE: when any req is high, select a winner (see Configuration), then latch its id, we, addr, wdata and mask. A read goes to AR; a write goes to AWW.
- AR: `ar_valid_o`=1 with the latched addr/id; on `ar_ready_i` go to R.
- R: `r_ready_o`=1; on `r_valid_i` latch `r_data_i`, set err = (`r_resp_i`!=0) | (`r_id_i`!=latched id), then go to RESP.
- AWW: `aw_valid_o` and `w_valid_o` both assert on entry. Each drops independently after its own handshake. When both handshakes are done (same or different cycles), go to B.
- B: `b_ready_o`=1; on `b_valid_i` set err = (`b_resp_i`!=0) | (`b_id_i`!=id), rdata=0, then go to RESP.
- RESP: the granted client's done=1 for exactly one cycle, with rdata/err; then go to IDLE. Non-granted clients keep done=0, rdata=0, err=0.
- Latched request fields are frozen from grant to RESP. A req dropped mid-transaction does not abort it; done still pulses.
- The client drops req at the edge ending RESP. IDLE therefore never re-grants a just-served request.

## Timing
- Reset (`rst`=0 at an edge): state=IDLE and every output is 0 (all valids/readies, done, err, rdata, addr, data, strb, id).
- Reset mid-transaction abandons the AXI transfer; the bridge is reset by the same `rst`.
- All outputs are registered or decoded from state only; no combinational path from `*_ready_i`/`*_valid_i` to outputs.
- Read with zero-wait AXI: req at cycle 0 → AR valid in cycle 1 → R in cycle 2 → done in cycle 3.
- Write with zero-wait AXI: req at cycle 0 → AW+W in cycle 1 → B in cycle 2 → done in cycle 3.
- Back-to-back requests: next grant earliest in the IDLE cycle after RESP, so 4 cycles per transaction minimum.
- Any number of wait cycles is tolerated on any channel. valid holds with stable payload until ready.

## Configuration
- `ARB_RR_EN` defined: round-robin. The last-granted client becomes lowest priority; after reset the order is dcache > uncache > icache.
- `ARB_RR_EN` undefined: fixed priority dcache > uncache > icache. No rotation state is built.

## Test plan
- Reset: hold `rst`=0 with all reqs high → every output 0 and no valid asserted; release → dcache is granted first.
- icache read at addr 0x8000_0000, AXI returns data 0x1122334455667788, id 0, resp 0 after 2 wait cycles → `icache_done_o` pulses once with that data and err=0.
- dcache write of 0xDEAD_BEEF_0000_0001, mask 0x0F, with `aw_ready_i` 3 cycles before `w_ready_i` → AW drops first, W holds; then B; done with err=0.
- uncache read returning `r_resp_i`=2'b10, then a read returning id 3 → `uncache_err_o`=1 on both done pulses.
- All three reqs held continuously. Fixed priority: the dcache-then-uncache pair repeats and icache starves. `ARB_RR_EN`: grants cycle dcache, uncache, icache.
- `rst` pulled low in state R while `r_valid_i` arrives → no done pulse; state IDLE on the next cycle.
